// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
//   Requester-side interface for one master port on the shared, arbitrated bus.
//   Takes one access at a time from a CPU pipeline stage. It requests the bus,
//   waits for the grant, issues a single address strobe, and waits for the
//   slave's ready. It then returns read data and releases the CPU stall.
//
//   State | Meaning
//   ------+-------------------------------------------------------------------
//   IDLE  | no access in flight; a new cpu_as_ (not flushed) is latched here
//   REQ   | bus_req_ low, waiting for bus_grnt_
//   ACCESS| bus owned; bus_as_ pulsed on entry, waiting for bus_rdy_/timeout
//   DONE  | result (rd_data/err) stable; held while the pipeline stalls
//
// Parameters
//   ADDR_W   word-address width
//   DATA_W   data width
//   TIMEOUT  max ACCESS cycles waiting for bus_rdy_ (0 = wait forever)
//
// Ports
//   clk, reset_          clock and asynchronous active-low reset
//   cpu_as_, cpu_rw,     CPU access strobe (active low), direction (1 = read),
//   cpu_addr, cpu_wr_data  address and write data
//   stall, flush         pipeline stall (holds DONE), flush (blocks new access)
//   busy                 combinational CPU stall while an access is in flight
//   rd_data, err         registered read result and timeout flag
//   bus_req_, bus_grnt_  arbiter request (out) and grant (in), active low
//   bus_as_, bus_rw,     registered bus address strobe, direction, address,
//   bus_addr, bus_wr_data  write data
//   bus_rdy_, bus_rd_data  slave ready (active low) and read data
// -----------------------------------------------------------------------------
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cpu_as_,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic              bus_rdy_,
    input  logic [DATA_W-1:0] bus_rd_data
);

    localparam int               CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic start_req;
    logic timeout_hit;

    assign start_req   = ~cpu_as_ & ~flush;
    // With TIMEOUT == 0 the terminal compare is disabled and the count is inert.
    assign timeout_hit = (TIMEOUT != 0) && (count_q == CNT_TC);

    // State and output registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q       <= S_IDLE;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            err_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            err_q         <= err_d;
            count_q       <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_req) state_d = S_REQ;
            S_REQ:    if (!bus_grnt_) state_d = S_ACCESS;
            // Ready has priority over timeout, but both end the access.
            S_ACCESS: if (!bus_rdy_ || timeout_hit) state_d = S_DONE;
            S_DONE:   if (!stall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        err_d         = err_q;
        count_d       = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    bus_rw_d      = cpu_rw;
                    bus_addr_d    = cpu_addr;
                    bus_wr_data_d = cpu_wr_data;
                    bus_req_d     = 1'b0;
                    err_d         = 1'b0;
                end
            end
            S_REQ: begin
                bus_req_d = 1'b0;
                if (!bus_grnt_) begin
                    bus_as_d = 1'b0;
                    count_d  = '0;
                end
            end
            S_ACCESS: begin
                // Strobe lasts exactly the first ACCESS cycle.
                bus_as_d = 1'b1;
                if (!bus_rdy_) begin
                    if (bus_rw_q) rd_data_d = bus_rd_data;
                    bus_req_d = 1'b1;
                end else if (timeout_hit) begin
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    bus_req_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            S_DONE: begin
                bus_req_d = 1'b1;
            end
            default: begin
                bus_req_d = 1'b1;
                bus_as_d  = 1'b1;
            end
        endcase
    end

    // Combinational stall includes the cycle a new access is presented in IDLE.
    always_comb begin
        busy = (state_q == S_REQ) || (state_q == S_ACCESS) ||
               ((state_q == S_IDLE) && start_req);
    end

    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign rd_data     = rd_data_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
//   Self-checking bench for bus_master_if (TIMEOUT = 8). A table of accesses
//   (inputs plus hand-computed expected result) is replayed cycle by cycle.
//   Expected results enter a scoreboard when the CPU strobe is driven and are
//   compared when the access reaches DONE. Flush-in-IDLE and reset-mid-access
//   are separate hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

    logic        clk = 1'b0;
    logic        reset_;
    logic        cpu_as_;
    logic        cpu_rw;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [31:0] rd_data;
    logic        err;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        bus_rdy_;
    logic [31:0] bus_rd_data;

    bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset_(reset_),
        .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .stall(stall), .flush(flush),
        .busy(busy), .rd_data(rd_data), .err(err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rdy_(bus_rdy_), .bus_rd_data(bus_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;    // cycles of grant-high in REQ; 0 = grant already low
        int          rdy_dly;    // ACCESS cycle index of bus_rdy_; -1 = never
        logic [31:0] rdata;
        int          stall_n;    // extra DONE cycles held by stall
        bit          flush_mid;  // flush high throughout REQ/ACCESS
        bit          rdy_in_req; // spurious bus_rdy_ while still in REQ
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] prev_rd  = '0;
    logic        prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, " bus_req_"}, bus_req_, 1'b1);
        chk1({tag, " bus_as_"}, bus_as_, 1'b1);
        chk1({tag, " bus_rw"}, bus_rw, 1'b1);
        chk({tag, " bus_addr"}, {2'b00, bus_addr}, 32'h0);
        chk({tag, " bus_wr_data"}, bus_wr_data, 32'h0);
        chk({tag, " rd_data"}, rd_data, 32'h0);
        chk1({tag, " err"}, err, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
    endtask

    task automatic drive_idle();
        cpu_as_  = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        bus_rdy_ = 1'b1;
        bus_rd_data = 32'hBAD0_BAD0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    done_c;
        int    last_c;
        bit    rdy_ok;
        bit    req_rdy;
        exp_t  e;
        string tag;
        done_c = 3 + v.gnt_dly + ((v.rdy_dly < 0) ? 7 : v.rdy_dly);
        last_c = done_c + v.stall_n;
        e      = '{prev_rd, prev_err};
        for (int cyc = 0; cyc <= last_c; cyc++) begin
            @(posedge clk);
            #1;
            cpu_as_ = !((cyc == 0) || (v.stall_n > 0 && cyc >= done_c && cyc < last_c));
            if (cyc == 0) begin
                cpu_rw      = v.rw;
                cpu_addr    = v.addr;
                cpu_wr_data = v.wdata;
                sb.push_back(exp_t'{v.exp_rd, v.exp_err});
            end else begin
                cpu_rw      = ~v.rw;
                cpu_addr    = ~v.addr;
                cpu_wr_data = ~v.wdata;
            end
            flush     = v.flush_mid && cyc >= 1 && cyc < done_c;
            stall     = (cyc < last_c);
            bus_grnt_ = !((v.gnt_dly == 0) || (cyc >= 1 + v.gnt_dly));
            rdy_ok    = (v.rdy_dly >= 0) && (cyc == 2 + v.gnt_dly + v.rdy_dly);
            req_rdy   = v.rdy_in_req && cyc >= 1 && cyc <= 1 + v.gnt_dly;
            bus_rdy_  = !(rdy_ok || req_rdy);
            bus_rd_data = rdy_ok ? v.rdata : 32'hBAD0_BAD0;
            @(negedge clk);
            tag = $sformatf("v%0d c%0d", idx, cyc);
            chk1({tag, " busy"}, busy, cyc < done_c);
            chk1({tag, " bus_req_"}, bus_req_, !(cyc >= 1 && cyc < done_c));
            chk1({tag, " bus_as_"}, bus_as_, cyc != 2 + v.gnt_dly);
            if (cyc >= 1) begin
                chk1({tag, " bus_rw"}, bus_rw, v.rw);
                chk({tag, " bus_addr"}, {2'b00, bus_addr}, {2'b00, v.addr});
                chk({tag, " bus_wr_data"}, bus_wr_data, v.wdata);
            end
            if (cyc == done_c) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s scoreboard act=empty exp=entry", tag);
                end else begin
                    e = sb.pop_front();
                end
            end
            if (cyc < done_c) begin
                chk({tag, " rd_data held"}, rd_data, prev_rd);
                chk1({tag, " err pre"}, err, (cyc == 0) ? prev_err : 1'b0);
            end else begin
                chk({tag, " rd_data"}, rd_data, e.rd);
                chk1({tag, " err"}, err, e.err);
            end
        end
        prev_rd  = v.exp_rd;
        prev_err = v.exp_err;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        tag = $sformatf("v%0d idle", idx);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " bus_req_"}, bus_req_, 1'b1);
        chk({tag, " rd_data"}, rd_data, prev_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t clean;
        //         rw    addr           wdata         g  r   rdata         st fl rq exp_rd        err
        vecs[0] = '{1'b1, 30'h0000_0040, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 30'h0000_0100, 32'h1234_5678, 5, 2, 32'hFFFF_0000, 0, 0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 30'h0000_002A, 32'h0BAD_F00D, 1, 0, 32'hCAFE_F00D, 4, 0, 0, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 30'h3FFF_FFFF, 32'h0000_0001, 0, -1, 32'h1111_1111, 0, 0, 0, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 30'h0000_0005, 32'h0000_0002, 2, 7, 32'hA5A5_A5A5, 0, 0, 0, 32'hA5A5_A5A5, 1'b0};
        vecs[5] = '{1'b0, 30'h0000_0007, 32'h0000_0000, 0, -1, 32'h7777_7777, 0, 0, 0, 32'h0000_0000, 1'b1};
        vecs[6] = '{1'b1, 30'h0000_0009, 32'h0000_0003, 0, 3, 32'h1357_9BDF, 0, 1, 0, 32'h1357_9BDF, 1'b0};
        vecs[7] = '{1'b1, 30'h0000_1234, 32'h0000_0004, 3, 1, 32'h2468_ACE0, 0, 0, 1, 32'h2468_ACE0, 1'b0};
        vecs[8] = '{1'b0, 30'h0000_0055, 32'hFFFF_FFFF, 0, 0, 32'h5555_AAAA, 2, 0, 0, 32'h2468_ACE0, 1'b0};
        clean   = '{1'b1, 30'h0000_0321, 32'h0000_0000, 1, 1, 32'hFEED_FACE, 0, 0, 0, 32'hFEED_FACE, 1'b0};

        reset_      = 1'b0;
        cpu_rw      = 1'b0;
        cpu_addr    = '0;
        cpu_wr_data = '0;
        bus_grnt_   = 1'b1;
        drive_idle();
        @(negedge clk);
        chk_reset_vals("reset");
        #2 reset_ = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Flush in IDLE blocks the request entirely, even with grant parked here.
        bus_grnt_ = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            cpu_as_  = 1'b0;
            cpu_rw   = 1'b1;
            cpu_addr = 30'h0000_0ABC;
            flush    = 1'b1;
            @(negedge clk);
            chk1($sformatf("flush c%0d busy", c), busy, 1'b0);
            chk1($sformatf("flush c%0d bus_req_", c), bus_req_, 1'b1);
            chk1($sformatf("flush c%0d bus_as_", c), bus_as_, 1'b1);
        end
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        chk1("flush after bus_req_", bus_req_, 1'b1);
        chk({"flush after bus_addr"}, {2'b00, bus_addr}, 32'h0000_0055);

        // Reset asserted while bus_as_ is low in the first ACCESS cycle.
        @(posedge clk);
        #1;
        cpu_as_     = 1'b0;
        cpu_rw      = 1'b0;
        cpu_addr    = 30'h0000_0077;
        cpu_wr_data = 32'h9999_9999;
        bus_grnt_   = 1'b0;
        @(posedge clk);
        #1;
        cpu_as_ = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("prereset bus_as_", bus_as_, 1'b0);
        chk1("prereset bus_req_", bus_req_, 1'b0);
        #2 reset_ = 1'b0;
        #1;
        chk_reset_vals("async reset");
        #1 reset_ = 1'b1;
        @(negedge clk);
        chk1("postreset busy", busy, 1'b0);
        chk1("postreset bus_req_", bus_req_, 1'b1);
        chk1("postreset bus_as_", bus_as_, 1'b1);
        prev_rd  = '0;
        prev_err = 1'b0;
        run_vec(9, clean);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
